// File: rtl/video_pkg.sv
// Shared types and constants for the Pocket video output path.
//   rgb_t        : packed {R,G,B} pixel at the default 8-bit channel depth
//   SLOT_W       : width of the scaler-slot request field
//   CMD_SLOT_PAD : zero padding above the slot in the end-of-line command word
//   slot_cmd()   : builds the end-of-line command word for a given slot
package video_pkg;

  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned SLOT_W       = 3;
  localparam int unsigned CMD_SLOT_PAD = 3 * DW_DEF - SLOT_W;

  typedef logic [3*DW_DEF-1:0] rgb_t;

  function automatic rgb_t slot_cmd(input logic [SLOT_W-1:0] slot);
    return {{CMD_SLOT_PAD{1'b0}}, slot};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Clock-enable qualified edge detector for a level signal.
// The history register only advances on ce, so edges are measured in
// pixel time. Both outputs are combinational and only assert while ce=1.
//   clk, reset : system clock, synchronous active-high reset
//   ce         : sample qualifier
//   d          : level input
//   rise, fall : d went 1 / went 0 relative to the previous ce sample
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
    end else if (ce) begin
      prev <= d;
    end
  end

  assign rise = ce &  d & ~prev;
  assign fall = ce & ~d &  prev;

endmodule

// File: rtl/video_pocket_formatter.sv
// Final video stage feeding the Pocket scaler.
// Converts level syncs to 1-clk pulses, qualifies DE with a skip flag on
// clocks that carry no new pixel, blanks RGB outside active video, inserts a
// scaler-slot command word on the clock after each active line ends, and
// measures active width/height of every frame (published on VS rise).
//   clk, reset         : system clock, synchronous active-high reset
//   ce_pix             : pixel clock-enable; inputs sampled only when high
//   r_in, g_in, b_in   : pixel colour
//   hs_in, vs_in       : active-high level syncs
//   hb_in, vb_in       : blanking status (DE alone defines active video)
//   de_in              : data enable
//   scaler_slot        : scaler mode request, latched at VS rise
//   video_rgb          : {R,G,B}, command word, or zero
//   video_de/video_skip: active pixel / active but no new pixel this clk
//   video_hs/video_vs  : 1-clk sync pulses
//   active_width/height: measurements of the last complete frame
//   frame_done         : 1-clk pulse when the measurements update
module video_pocket_formatter
  import video_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [DW-1:0]     r_in,
  input  logic [DW-1:0]     g_in,
  input  logic [DW-1:0]     b_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              hb_in,
  input  logic              vb_in,
  input  logic              de_in,
  input  logic [SLOT_W-1:0] scaler_slot,
  output logic [3*DW-1:0]   video_rgb,
  output logic              video_de,
  output logic              video_skip,
  output logic              video_hs,
  output logic              video_vs,
  output logic [XW-1:0]     active_width,
  output logic [YW-1:0]     active_height,
  output logic              frame_done
);

  logic hs_rise, hs_fall_nc;
  logic vs_rise, vs_fall_nc;
  logic de_rise_nc, de_fall;

  // Blank flags are informational only; DE is the sole active-video qualifier.
  logic unused_blank;
  assign unused_blank = ^{hb_in, vb_in, hs_fall_nc, vs_fall_nc, de_rise_nc};

  sync_edge_det u_hs_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix),
    .d     (hs_in),
    .rise  (hs_rise),
    .fall  (hs_fall_nc)
  );

  sync_edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix),
    .d     (vs_in),
    .rise  (vs_rise),
    .fall  (vs_fall_nc)
  );

  sync_edge_det u_de_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix),
    .d     (de_in),
    .rise  (de_rise_nc),
    .fall  (de_fall)
  );

  logic [XW-1:0]     x_cnt, width_q, x_inc;
  logic [YW-1:0]     y_cnt, y_inc;
  logic [SLOT_W-1:0] slot_q;
  logic [3*DW-1:0]   cmd_word;

  assign x_inc    = (x_cnt == '1) ? x_cnt : x_cnt + 1'b1;
  assign y_inc    = (y_cnt == '1) ? y_cnt : y_cnt + 1'b1;
  assign cmd_word = {{(3*DW-SLOT_W){1'b0}}, slot_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      video_rgb     <= '0;
      video_de      <= 1'b0;
      video_skip    <= 1'b0;
      video_hs      <= 1'b0;
      video_vs      <= 1'b0;
      frame_done    <= 1'b0;
      active_width  <= '0;
      active_height <= '0;
      x_cnt         <= '0;
      width_q       <= '0;
      y_cnt         <= '0;
      slot_q        <= '0;
    end else begin
      video_hs   <= hs_rise;
      video_vs   <= vs_rise;
      frame_done <= vs_rise;
      video_skip <= video_de & ~ce_pix;
      video_rgb  <= '0;

      if (ce_pix) begin
        video_de <= de_in;
        if (de_in) begin
          video_rgb <= {r_in, g_in, b_in};
          x_cnt     <= x_inc;
        end else if (de_fall) begin
          video_rgb <= cmd_word;
        end
      end

      if (de_fall) begin
        width_q <= x_cnt;
        x_cnt   <= '0;
        y_cnt   <= y_inc;
      end

      // On a coincident DE fall the closing line is published directly and
      // the later clears below override the line-end updates above.
      if (vs_rise) begin
        active_width  <= de_fall ? x_cnt : width_q;
        active_height <= de_fall ? y_inc : y_cnt;
        width_q       <= '0;
        y_cnt         <= '0;
        slot_q        <= scaler_slot;
      end
    end
  end

endmodule

// File: tb/tb_video_pocket_formatter.sv
module tb_video_pocket_formatter;
  import video_pkg::*;

  logic       clk = 1'b0;
  logic       reset, ce_pix;
  logic [7:0] r_in, g_in, b_in;
  logic       hs_in, vs_in, hb_in, vb_in, de_in;
  logic [2:0] scaler_slot;

  logic [23:0] rgb_b, rgb_s;
  logic        de_b, skip_b, hs_b, vs_b, fd_b;
  logic        de_s, skip_s, hs_s, vs_s, fd_s;
  logic [9:0]  aw_b;
  logic [3:0]  aw_s;
  logic [8:0]  ah_b, ah_s;

  always #5 clk = ~clk;

  video_pocket_formatter #(.DW(8), .XW(10), .YW(9)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in), .de_in(de_in),
    .scaler_slot(scaler_slot),
    .video_rgb(rgb_b), .video_de(de_b), .video_skip(skip_b),
    .video_hs(hs_b), .video_vs(vs_b),
    .active_width(aw_b), .active_height(ah_b), .frame_done(fd_b)
  );

  video_pocket_formatter #(.DW(8), .XW(4), .YW(9)) dut_s (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in), .de_in(de_in),
    .scaler_slot(scaler_slot),
    .video_rgb(rgb_s), .video_de(de_s), .video_skip(skip_s),
    .video_hs(hs_s), .video_vs(vs_s),
    .active_width(aw_s), .active_height(ah_s), .frame_done(fd_s)
  );

  typedef struct packed {
    rgb_t       rgb;
    logic       de, skip, hs, vs, fd;
    logic [9:0] aw;
    logic [8:0] ah;
  } out_t;

  typedef struct packed {
    out_t b;
    out_t s;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: last ce-sampled levels, pixel/line tallies, frame results
  int         m_hs, m_vs, m_de, m_deo;
  int         line_px, lines, last_w, meas_w, meas_h;
  logic [2:0] m_slot, cur_slot;
  int         ce_per;
  bit         vs_now;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clk_step(input bit rst_v, input bit ce_v, input bit hs_v,
                          input bit vs_v, input bit de_v);
    out_t e;
    exp_t x;
    bit   hsr, vsr, fall;
    @(negedge clk);
    reset       = rst_v;
    ce_pix      = ce_v;
    r_in        = 8'($urandom);
    g_in        = 8'($urandom);
    b_in        = 8'($urandom);
    hs_in       = hs_v;
    vs_in       = vs_v;
    de_in       = de_v;
    hb_in       = 1'($urandom);
    vb_in       = 1'($urandom);
    scaler_slot = cur_slot;
    e = '0;
    if (rst_v) begin
      m_hs = 0; m_vs = 0; m_de = 0; m_deo = 0;
      line_px = 0; lines = 0; last_w = 0; meas_w = 0; meas_h = 0;
      m_slot = 3'd0;
    end else begin
      hsr  = ce_v && hs_v && (m_hs == 0);
      vsr  = ce_v && vs_v && (m_vs == 0);
      fall = ce_v && !de_v && (m_de != 0);
      e.skip = (m_deo != 0) && !ce_v;
      if (ce_v) m_deo = int'(de_v);
      e.de = (m_deo != 0);
      e.hs = hsr;
      e.vs = vsr;
      e.fd = vsr;
      if (ce_v && de_v) begin
        e.rgb = {r_in, g_in, b_in};
        line_px++;
      end else if (fall) begin
        e.rgb = slot_cmd(m_slot);
      end
      if (fall) begin
        last_w  = line_px;
        line_px = 0;
        lines++;
      end
      if (vsr) begin
        meas_w = last_w;
        meas_h = lines;
        lines  = 0;
        last_w = 0;
        m_slot = cur_slot;
      end
      if (ce_v) begin
        m_hs = int'(hs_v);
        m_vs = int'(vs_v);
        m_de = int'(de_v);
      end
    end
    e.ah = 9'(sat(meas_h, 511));
    x.b = e;
    x.s = e;
    x.b.aw = 10'(sat(meas_w, 1023));
    x.s.aw = 10'(sat(meas_w, 15));
    sb.push_back(x);
  endtask

  task automatic pix(input bit hs_v, input bit vs_v, input bit de_v);
    clk_step(1'b0, 1'b1, hs_v, vs_v, de_v);
    repeat (ce_per - 1) clk_step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic line(input int w, input int nblank, input int hs_len, input bit vs_at_blank);
    for (int i = 0; i < w; i++) pix(1'b0, vs_now, 1'b1);
    if (vs_at_blank) vs_now = 1'b1;
    for (int i = 0; i < nblank; i++) pix((i >= 1) && (i < 1 + hs_len), vs_now, 1'b0);
  endtask

  task automatic vblank();
    vs_now = 1'b1;
    line(0, 12, 10, 1'b0);
    line(0, 12, 10, 1'b0);
    vs_now = 1'b0;
    line(0, 4, 2, 1'b0);
  endtask

  task automatic frame(input int w, input int h, input bit coincident,
                       input int slot_line, input logic [2:0] new_slot);
    for (int l = 0; l < h; l++) begin
      if (l == slot_line) cur_slot = new_slot;
      line(w, 4, 2, coincident && (l == h - 1));
    end
    vblank();
  endtask

  // Monitor: every output clock is popped and compared against the model
  initial begin
    exp_t x;
    out_t gb, gs;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x  = sb.pop_front();
        gb = '{rgb_b, de_b, skip_b, hs_b, vs_b, fd_b, aw_b, ah_b};
        gs = '{rgb_s, de_s, skip_s, hs_s, vs_s, fd_s, {6'd0, aw_s}, ah_s};
        checks++;
        if (gb !== x.b || gs !== x.s) begin
          errors++;
          $display("FAIL stream t=%0t: got %h / %h want %h / %h", $time, gb, gs, x.b, x.s);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; ce_pix = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0; de_in = 1'b0;
    scaler_slot = '0; cur_slot = 3'd0; vs_now = 1'b0; ce_per = 1;

    repeat (3) clk_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held 4 clocks in the middle of an active line
    ce_per = 4;
    for (int i = 0; i < 30; i++) pix(1'b0, 1'b0, 1'b1);
    repeat (4) clk_step(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b1);
    clk_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rgb", int'(rgb_b), 0);
    check("rst_de", int'(de_b), 0);
    check("rst_pulses", int'({hs_b, vs_b, fd_b, skip_b}), 0);
    check("rst_width", int'(aw_b), 0);
    check("rst_height", int'(ah_b), 0);

    vblank();
    check("first_frame_width", int'(aw_b), 0);

    // 160x102 at 1-in-4 ce, slot 5 requested mid-frame
    frame(160, 102, 1'b0, 50, 3'd5);
    check("w160", int'(aw_b), 160);
    check("h102", int'(ah_b), 102);

    // Same geometry, DE fall on last line coincides with VS rise
    ce_per = 1;
    frame(160, 102, 1'b1, -1, 3'd0);
    check("coinc_w160", int'(aw_b), 160);
    check("coinc_h102", int'(ah_b), 102);

    // 20-pixel lines saturate the narrow counter
    ce_per = 2;
    frame(20, 5, 1'b0, -1, 3'd0);
    check("w20", int'(aw_b), 20);
    check("w20_sat", int'(aw_s), 15);
    check("h5", int'(ah_s), 5);

    // Frame without any DE
    vblank();
    check("node_w", int'(aw_b), 0);
    check("node_h", int'(ah_b), 0);

    repeat (4) begin
      ce_per = $urandom_range(1, 3);
      frame($urandom_range(1, 40), $urandom_range(1, 6), 1'($urandom),
            $urandom_range(0, 5), 3'($urandom));
    end

    repeat (3) clk_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
